// File: rtl/srl_err_uart_pkg.sv
// Shared types and constants for the SRL error-report UART.
// Optional header frame is selected with SRL_ERR_UART_HEADER_EN (see srl_err_uart_tx).
package srl_err_uart_pkg;

  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned FRAME_BITS = 10;
  localparam int unsigned BIT_IDX_W  = 4;

  localparam logic [BYTE_W-1:0] HDR_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_START,
    ST_DATA,
    ST_STOP
  } state_t;

  // 8N1 frame, sent LSB first: start bit in [0], stop bit in [9].
  function automatic logic [FRAME_BITS-1:0] frame_of(input logic [BYTE_W-1:0] b);
    return {1'b1, b, 1'b0};
  endfunction

endpackage

// File: rtl/srl_err_uart_shifter.sv
// Baud counter plus frame shifter: serialises one 8N1 frame per load, line held in a flop.
// Shared by header and status frames.
module srl_err_uart_shifter
  import srl_err_uart_pkg::*;
#(
  parameter int unsigned CLK_DIV = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_load,
  input  logic [BYTE_W-1:0]    i_data,
  output logic                 o_tx,
  output logic                 o_bit_end_c,
  output logic                 o_done_c,
  output logic [BIT_IDX_W-1:0] o_bit_idx
);

  localparam int unsigned BAUD_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIV - 1);
  localparam logic [BIT_IDX_W-1:0] IDX_LAST = BIT_IDX_W'(FRAME_BITS - 1);

  logic [BAUD_W-1:0]     r_baud;
  logic [FRAME_BITS-1:0] r_shift;
  logic [BIT_IDX_W-1:0]  r_bit_idx;
  logic                  r_active;
  logic                  r_tx;
  logic                  w_bit_end;
  logic                  w_last_bit;

  assign w_bit_end  = r_active && (r_baud == BAUD_LAST);
  assign w_last_bit = (r_bit_idx == IDX_LAST);

  // The line level is always the registered head of the frame; idle and reset drive 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_baud    <= '0;
      r_shift   <= '1;
      r_bit_idx <= '0;
      r_active  <= 1'b0;
      r_tx      <= 1'b1;
    end else if (i_load) begin
      r_shift   <= frame_of(i_data);
      r_tx      <= 1'b0;
      r_baud    <= '0;
      r_bit_idx <= '0;
      r_active  <= 1'b1;
    end else if (r_active) begin
      if (w_bit_end) begin
        r_baud <= '0;
        if (w_last_bit) begin
          r_active <= 1'b0;
          r_tx     <= 1'b1;
        end else begin
          r_shift   <= {1'b1, r_shift[FRAME_BITS-1:1]};
          r_tx      <= r_shift[1];
          r_bit_idx <= r_bit_idx + BIT_IDX_W'(1);
        end
      end else begin
        r_baud <= r_baud + BAUD_W'(1);
      end
    end
  end

  assign o_tx        = r_tx;
  assign o_bit_end_c = w_bit_end;
  assign o_done_c    = w_bit_end && w_last_bit;
  assign o_bit_idx   = r_bit_idx;

endmodule

// File: rtl/srl_err_uart_tx.sv
// Sticky OR of SRL checker error flags, reported over UART on new bits and periodically.
// Define SRL_ERR_UART_HEADER_EN to precede each status byte with an 8'hA5 header frame.
module srl_err_uart_tx
  import srl_err_uart_pkg::*;
#(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned CLK_DIV       = 16,
  parameter int unsigned REPORT_PERIOD = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] err_in,
  input  logic             clear,
  output logic [WIDTH-1:0] err_sticky,
  output logic             tx,
  output logic             busy
);

  localparam int unsigned PERIOD_W = (REPORT_PERIOD > 1) ? $clog2(REPORT_PERIOD) : 1;
  localparam logic [PERIOD_W-1:0] PERIOD_LAST = PERIOD_W'(REPORT_PERIOD - 1);

  logic                 r_rst_meta;
  logic                 r_rst_sync;
  logic                 w_rst_n;
  logic [WIDTH-1:0]     r_sticky;
  logic [WIDTH-1:0]     w_sticky_nxt;
  logic                 w_new_bit;
  logic [PERIOD_W-1:0]  r_period;
  logic                 w_period_hit;
  logic                 r_pending;
  logic                 r_busy;
  state_t               r_state;
  state_t               w_state_nxt;
  logic                 w_load;
  logic                 w_launch;
  logic [BYTE_W-1:0]    w_load_data;
  logic                 w_tx;
  logic                 w_bit_end;
  logic                 w_done;
  logic [BIT_IDX_W-1:0] w_bit_idx;

  // Reset asserts asynchronously, releases on a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rst_meta <= 1'b0;
      r_rst_sync <= 1'b0;
    end else begin
      r_rst_meta <= 1'b1;
      r_rst_sync <= r_rst_meta;
    end
  end

  assign w_rst_n = r_rst_sync;

  // New error bits win over a simultaneous clear.
  assign w_sticky_nxt = (clear ? '0 : r_sticky) | err_in;
  assign w_new_bit    = |(w_sticky_nxt & ~r_sticky);
  assign w_period_hit = (REPORT_PERIOD != 0) && (r_period == PERIOD_LAST);

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_sticky <= '0;
      r_period <= '0;
    end else begin
      r_sticky <= w_sticky_nxt;
      if ((REPORT_PERIOD == 0) || w_period_hit) begin
        r_period <= '0;
      end else begin
        r_period <= r_period + PERIOD_W'(1);
      end
    end
  end

  // Triggers during a report coalesce into a single follow-up report.
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_pending <= 1'b0;
    end else if (w_new_bit || w_period_hit) begin
      r_pending <= 1'b1;
    end else if (w_launch) begin
      r_pending <= 1'b0;
    end
  end

`ifdef SRL_ERR_UART_HEADER_EN
  logic [BYTE_W-1:0] r_snap;
  logic              r_hdr_phase;

  // Status byte is frozen when the header frame is launched.
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_snap      <= '0;
      r_hdr_phase <= 1'b0;
    end else if (w_launch) begin
      r_snap      <= BYTE_W'(r_sticky);
      r_hdr_phase <= 1'b1;
    end else if (r_state == ST_HDR) begin
      r_hdr_phase <= 1'b0;
    end
  end
`endif

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != ST_IDLE);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_launch    = 1'b0;
    w_load_data = BYTE_W'(r_sticky);
    case (r_state)
      ST_IDLE: begin
        if (r_pending) begin
          w_launch    = 1'b1;
          w_load      = 1'b1;
          w_state_nxt = ST_START;
`ifdef SRL_ERR_UART_HEADER_EN
          w_load_data = HDR_BYTE;
`endif
        end
      end
      ST_HDR: begin
`ifdef SRL_ERR_UART_HEADER_EN
        w_load      = 1'b1;
        w_load_data = r_snap;
        w_state_nxt = ST_START;
`else
        w_state_nxt = ST_IDLE;
`endif
      end
      ST_START: begin
        if (w_bit_end) begin
          w_state_nxt = ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_bit_end && (w_bit_idx == BIT_IDX_W'(FRAME_BITS - 2))) begin
          w_state_nxt = ST_STOP;
        end
      end
      ST_STOP: begin
        if (w_done) begin
`ifdef SRL_ERR_UART_HEADER_EN
          w_state_nxt = r_hdr_phase ? ST_HDR : ST_IDLE;
`else
          w_state_nxt = ST_IDLE;
`endif
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  srl_err_uart_shifter #(
    .CLK_DIV(CLK_DIV)
  ) u_shifter (
    .clk        (clk),
    .rst_n      (w_rst_n),
    .i_load     (w_load),
    .i_data     (w_load_data),
    .o_tx       (w_tx),
    .o_bit_end_c(w_bit_end),
    .o_done_c   (w_done),
    .o_bit_idx  (w_bit_idx)
  );

  assign err_sticky = r_sticky;
  assign tx         = w_tx;
  assign busy       = r_busy;

endmodule

// File: tb/tb_srl_err_uart_tx.sv
// Scoreboard bench for srl_err_uart_tx: a UART receiver monitor decodes frames and pops expected bytes.
`timescale 1ns/1ps
module tb_srl_err_uart_tx;

  localparam int unsigned CLK_DIV = 4;
`ifdef SRL_ERR_UART_HEADER_EN
  localparam int unsigned BUSY_W = 20 * CLK_DIV + 1;
`else
  localparam int unsigned BUSY_W = 10 * CLK_DIV;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, clear, rst_n_p, clear_p;
  logic [7:0] err_in, err_in_p;
  wire  [7:0] err_sticky, err_sticky_p;
  wire        tx, busy, tx_p, busy_p;

  srl_err_uart_tx #(.WIDTH(8), .CLK_DIV(CLK_DIV), .REPORT_PERIOD(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .err_in(err_in), .clear(clear),
    .err_sticky(err_sticky), .tx(tx), .busy(busy)
  );

  srl_err_uart_tx #(.WIDTH(8), .CLK_DIV(CLK_DIV), .REPORT_PERIOD(64)) u_dut_p (
    .clk(clk), .rst_n(rst_n_p), .err_in(err_in_p), .clear(clear_p),
    .err_sticky(err_sticky_p), .tx(tx_p), .busy(busy_p)
  );

  int          vectors = 0;
  int          miscompares = 0;
  int unsigned cyc = 0;
  logic [7:0]  exp_q0[$];
  logic [7:0]  exp_q1[$];
  int unsigned start_q0[$];
  int          starts1 = 0;
  int unsigned last_start1 = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void push_report(input int ch, input logic [7:0] b);
`ifdef SRL_ERR_UART_HEADER_EN
    if (ch == 0) exp_q0.push_back(8'hA5); else exp_q1.push_back(8'hA5);
`endif
    if (ch == 0) exp_q0.push_back(b); else exp_q1.push_back(b);
  endfunction

  // Called on the negedge where the start bit is first seen; samples each bit mid-period.
  task automatic rx_frame(input int ch, output logic [7:0] data, output logic start_ok,
                          output logic stop_ok, output bit aborted);
    logic line;
    data = '0; start_ok = 1'b0; stop_ok = 1'b0; aborted = 1'b0;
    for (int k = 0; k < 10; k++) begin
      repeat ((k == 0) ? 2 : CLK_DIV) @(negedge clk);
      if (((ch == 0) ? rst_n : rst_n_p) !== 1'b1) begin
        aborted = 1'b1;
        return;
      end
      line = (ch == 0) ? tx : tx_p;
      if (k == 0) start_ok = ~line;
      else if (k == 9) stop_ok = line;
      else data[k-1] = line;
    end
  endtask

  task automatic score(input int ch, input logic [7:0] d, input logic s0, input logic s9);
    logic [7:0] e;
    check(ch == 0 ? "start_bit_a" : "start_bit_b", 32'(s0), 32'd1);
    check(ch == 0 ? "stop_bit_a" : "stop_bit_b", 32'(s9), 32'd1);
    if ((ch == 0 ? exp_q0.size() : exp_q1.size()) == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL unexpected_frame_%0d: got 0x%0h, expected no frame (cycle %0d)", ch, d, cyc);
    end else begin
      e = (ch == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
      check(ch == 0 ? "frame_byte_a" : "frame_byte_b", 32'(d), 32'(e));
    end
  endtask

  initial begin : mon_a
    logic [7:0] d;
    logic s0, s9;
    bit ab;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && tx === 1'b0) begin
        start_q0.push_back(cyc);
        rx_frame(0, d, s0, s9, ab);
        if (!ab) score(0, d, s0, s9);
      end
    end
  end

  initial begin : mon_b
    logic [7:0] d;
    logic s0, s9;
    bit ab;
    forever begin
      @(negedge clk);
      if (rst_n_p === 1'b1 && tx_p === 1'b0) begin
        starts1++;
`ifndef SRL_ERR_UART_HEADER_EN
        if (starts1 >= 3) check("period_interval", cyc - last_start1, 32'd64);
`endif
        last_start1 = cyc;
        rx_frame(1, d, s0, s9, ab);
        if (!ab) score(1, d, s0, s9);
      end
    end
  end

  initial begin : mon_busy
    int w = 0;
    forever begin
      @(negedge clk);
      if (busy === 1'b1) begin
        w++;
      end else begin
        if (w != 0) check("busy_width", 32'(w), 32'(BUSY_W));
        w = 0;
      end
    end
  end

  initial begin : stim
    int seen;
    rst_n = 1'b0; rst_n_p = 1'b0; clear = 1'b0; clear_p = 1'b0;
    err_in = '0; err_in_p = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Quiet line after reset.
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      check("idle_line", {22'd0, tx, busy, err_sticky}, 32'h200);
    end

    // Single-cycle error pulse.
    @(posedge clk); #1 err_in = 8'h05; push_report(0, 8'h05);
    @(posedge clk); #1 err_in = 8'h00;
    @(negedge clk);
    check("sticky_after_pulse", 32'(err_sticky), 32'h05);
    check("busy_before_launch", 32'(busy), 32'd0);
    @(negedge clk);
    check("busy_rise", 32'(busy), 32'd1);
    check("tx_fall", 32'(tx), 32'd0);

    // New bit mid-frame: one follow-up only, after a single idle cycle.
    repeat (8) @(posedge clk);
    #1 err_in = 8'h80; push_report(0, 8'h85);
    @(posedge clk); #1 err_in = 8'h00;
    repeat (250) @(posedge clk);
    check("queue_a_drained_1", 32'(exp_q0.size()), 32'd0);
    check("sticky_85", 32'(err_sticky), 32'h85);
    if (start_q0.size() >= 2) begin
      check("b2b_gap", start_q0[1] - start_q0[0], 32'd41);
    end else begin
      vectors++; miscompares++;
      $display("FAIL b2b_gap: got %0d frames, expected at least 2", start_q0.size());
    end

    // Clear alone: no new bits, no frame.
    @(posedge clk); #1 clear = 1'b1;
    @(posedge clk); #1 clear = 1'b0;
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (busy !== 1'b0) seen++;
    end
    check("sticky_cleared", 32'(err_sticky), 32'h00);
    check("clear_no_frame", 32'(seen), 32'd0);

    @(posedge clk); #1 err_in = 8'h05; push_report(0, 8'h05);
    @(posedge clk); #1 err_in = 8'h00;
    repeat (150) @(posedge clk);

    // Clear and new bit together: the new bit survives and is reported.
    #1 clear = 1'b1; err_in = 8'h02; push_report(0, 8'h02);
    @(posedge clk); #1 clear = 1'b0; err_in = 8'h00;
    @(negedge clk);
    check("clear_with_err", 32'(err_sticky), 32'h02);
    repeat (150) @(posedge clk);
    #1 clear = 1'b1;
    @(posedge clk); #1 clear = 1'b0;
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (busy !== 1'b0) seen++;
    end
    check("clear_no_frame_2", 32'(seen), 32'd0);
    check("queue_a_drained_2", 32'(exp_q0.size()), 32'd0);

    // Periodic reports, then reset in the middle of a frame.
    @(posedge clk); #1 rst_n_p = 1'b1;
    repeat (5) @(posedge clk);
    #1 err_in_p = 8'h11;
`ifdef SRL_ERR_UART_HEADER_EN
    push_report(1, 8'h11); push_report(1, 8'h11);
`else
    for (int i = 0; i < 4; i++) push_report(1, 8'h11);
`endif
    @(posedge clk); #1 err_in_p = 8'h00;
    for (int i = 0; i < 2000 && starts1 < 5; i++) @(posedge clk);
    check("period_frames_seen", 32'(starts1 >= 5), 32'd1);
    repeat (9) @(posedge clk);
    #1 check("tx_mid_frame", 32'(tx_p), 32'd0);
    rst_n_p = 1'b0;
    #1;
    check("tx_async_reset", 32'(tx_p), 32'd1);
    check("sticky_async_reset", 32'(err_sticky_p), 32'h00);
    check("busy_async_reset", 32'(busy_p), 32'd0);
    repeat (60) @(posedge clk);
    check("queue_b_drained", 32'(exp_q1.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
